// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin burst arbiter sharing one SPI byte engine between two
// byte-stream requesters, with per-requester slave selects and setup/hold spacing.
module spi_xfer_arbiter #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CNT_W    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  last_i,
    input  logic [15:0] tx_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  gnt_o,
    output logic [7:0]  rx_o,
    output logic [1:0]  rx_valid_o,
    output logic        eng_start_o,
    output logic [7:0]  eng_tx_o,
    input  logic        eng_busy_i,
    input  logic        eng_done_i,
    input  logic [7:0]  eng_rx_i,
    output logic [1:0]  spi_ss_o
);
    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, NEXT, HOLD} state_t;

    state_t           state_q, state_d;
    logic             own_q, own_d, ptr_q, ptr_d, last_q, last_d, start_q, start_d;
    logic [1:0]       gnt_q, gnt_d, ack_q, ack_d, rxv_q, rxv_d;
    logic [7:0]       tx_q, tx_d, rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       own_oh;
    logic             own_req;
    logic [7:0]       own_tx;

    assign own_oh  = own_q ? 2'b10 : 2'b01;
    assign own_req = req_i[own_q];
    assign own_tx  = own_q ? tx_i[15:8] : tx_i[7:0];

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        start_d = 1'b0;
        ack_d   = 2'b00;
        rxv_d   = 2'b00;
        case (state_q)
            IDLE: if (|req_i) begin
                own_d   = (req_i == 2'b11) ? ptr_q : req_i[1];
                gnt_d   = own_d ? 2'b10 : 2'b01;
                cnt_d   = CNT_W'(CS_SETUP);
                state_d = (CS_SETUP == 0) ? START : SETUP;
            end
            SETUP: begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q <= CNT_W'(1)) ? START : SETUP;
            end
            START: if (!eng_busy_i && own_req) begin
                start_d = 1'b1;
                tx_d    = own_tx;
                ack_d   = own_oh;
                last_d  = last_i[own_q];
                state_d = WAIT;
            end
            WAIT: if (eng_done_i) begin
                rx_d    = eng_rx_i;
                rxv_d   = own_oh;
                cnt_d   = CNT_W'(CS_HOLD);
                state_d = last_q ? HOLD : NEXT;
            end
            NEXT: begin
                cnt_d   = CNT_W'(CS_HOLD);
                state_d = own_req ? START : HOLD;
            end
            HOLD: if (cnt_q == '0) begin
                gnt_d   = 2'b00;
                ptr_d   = ~own_q;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset also drops SS immediately, aborting any burst in flight.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            ptr_q   <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            rxv_q   <= 2'b00;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            start_q <= start_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rxv_q   <= rxv_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign ack_o       = ack_q;
    assign rx_valid_o  = rxv_q;
    assign rx_o        = rx_q;
    assign eng_start_o = start_q;
    assign eng_tx_o    = tx_q;
    assign spi_ss_o    = ~gnt_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: requester and engine models plus a burst-level round-robin reference
// whose expected grant order, bytes and SS timing are compared against logged DUT events.
module tb_spi_xfer_arbiter;
    localparam int SU = 2;
    localparam int HD = 3;

    typedef struct {int c; int o; logic [7:0] b;} ev_t;
    typedef struct {logic [7:0] rx; int lat;} eng_t;
    typedef struct {int o; int n; int early; int extra;} bur_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  last_i = 2'b00;
    logic [15:0] tx_i = 16'h0000;
    logic        eng_busy_i = 1'b0;
    logic        eng_done_i = 1'b0;
    logic [7:0]  eng_rx_i = 8'h00;
    logic [1:0]  ack_o, gnt_o, rx_valid_o, spi_ss_o;
    logic [7:0]  rx_o, eng_tx_o;
    logic        eng_start_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ev_t  starts[$], rxs[$], falls[$], rises[$];
    eng_t elog[$];
    bur_t exp_b[$], mbur0[$], mbur1[$];
    logic [7:0] exp_s[$], mb0[$], mb1[$];
    logic [9:0] rq0[$], rq1[$];
    int cur0 = 0, cur1 = 0, rr_ptr = 0;
    logic [1:0] pause = 2'b00, ss_prev = 2'b11;
    int ecnt = 0, bforce = 0, fix_lat = 0, fix_rx = -1;
    logic busy_test = 1'b0, stray = 1'b0;
    logic [7:0] erx_n = 8'h00;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(.CS_SETUP(SU), .CS_HOLD(HD), .CNT_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req_i), .last_i(last_i), .tx_i(tx_i),
        .ack_o(ack_o), .gnt_o(gnt_o), .rx_o(rx_o), .rx_valid_o(rx_valid_o),
        .eng_start_o(eng_start_o), .eng_tx_o(eng_tx_o), .eng_busy_i(eng_busy_i),
        .eng_done_i(eng_done_i), .eng_rx_i(eng_rx_i), .spi_ss_o(spi_ss_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Monitor, requester models and engine model all act on the falling edge.
    always @(negedge clk) begin
        logic [9:0] tmp;
        int lat;
        cyc++;
        checks++;
        assert ($onehot0(gnt_o) && $onehot0(ack_o) && $onehot0(rx_valid_o) &&
                (ack_o & ~gnt_o) == 2'b00 && (rx_valid_o & ~gnt_o) == 2'b00 &&
                spi_ss_o == ~gnt_o && (|ack_o) == eng_start_o) else begin
            failures++;
            $error("FAIL invariant gnt=%b ack=%b rxv=%b ss=%b start=%b", gnt_o, ack_o, rx_valid_o, spi_ss_o, eng_start_o);
        end
        if (eng_start_o) starts.push_back('{cyc, int'(ack_o[1]), eng_tx_o});
        if (|rx_valid_o) rxs.push_back('{cyc, int'(rx_valid_o[1]), rx_o});
        for (int i = 0; i < 2; i++) begin
            if (ss_prev[i] && !spi_ss_o[i]) begin
                falls.push_back('{cyc, i, 8'h00});
                if (busy_test) begin
                    bforce = SU + 5;
                    busy_test = 1'b0;
                end
            end
            if (!ss_prev[i] && spi_ss_o[i]) rises.push_back('{cyc, i, 8'h00});
        end
        ss_prev = spi_ss_o;
        if (ack_o[0] && rq0.size() > 0) begin
            if (rq0[0][9]) pause[0] = 1'b1;
            tmp = rq0.pop_front();
        end
        if (ack_o[1] && rq1.size() > 0) begin
            if (rq1[0][9]) pause[1] = 1'b1;
            tmp = rq1.pop_front();
        end
        for (int i = 0; i < 2; i++) if (pause[i] && !gnt_o[i]) pause[i] = 1'b0;
        req_i[0]    = rq0.size() > 0 && !pause[0];
        req_i[1]    = rq1.size() > 0 && !pause[1];
        tx_i[7:0]   = rq0.size() > 0 ? rq0[0][7:0] : 8'h00;
        tx_i[15:8]  = rq1.size() > 0 ? rq1[0][7:0] : 8'h00;
        last_i[0]   = rq0.size() > 0 ? rq0[0][8] : 1'b0;
        last_i[1]   = rq1.size() > 0 ? rq1[0][8] : 1'b0;
        eng_done_i = 1'b0;
        if (ecnt > 0) begin
            ecnt--;
            if (ecnt == 0) begin
                eng_done_i = 1'b1;
                eng_rx_i = erx_n;
            end
        end
        if (eng_start_o) begin
            lat = fix_lat > 0 ? fix_lat : int'($urandom_range(1, 6));
            erx_n = fix_rx >= 0 ? fix_rx[7:0] : 8'($urandom);
            ecnt = lat;
            elog.push_back('{erx_n, lat});
        end
        if (stray) begin
            eng_done_i = 1'b1;
            eng_rx_i = 8'($urandom);
            stray = 1'b0;
        end
        eng_busy_i = ecnt > 0 || bforce > 0;
        if (bforce > 0) bforce--;
    end

    task automatic add(input int o, input logic [7:0] b, input logic l, input logic d);
        if (o == 1) begin
            rq1.push_back({d, l, b});
            mb1.push_back(b);
            cur1++;
            if (l || d) begin
                mbur1.push_back('{1, cur1, int'(d), 0});
                cur1 = 0;
            end
        end else begin
            rq0.push_back({d, l, b});
            mb0.push_back(b);
            cur0++;
            if (l || d) begin
                mbur0.push_back('{0, cur0, int'(d), 0});
                cur0 = 0;
            end
        end
    endtask

    // Reference arbitration: whole bursts, pointer decides ties, pointer moves to the non-owner.
    task automatic plan(input int extra);
        bur_t b;
        int o;
        while (mbur0.size() > 0 || mbur1.size() > 0) begin
            if (mbur0.size() > 0 && mbur1.size() > 0) o = rr_ptr;
            else o = mbur1.size() > 0 ? 1 : 0;
            if (o == 1) b = mbur1.pop_front();
            else b = mbur0.pop_front();
            b.extra = extra;
            extra = 0;
            for (int k = 0; k < b.n; k++) begin
                if (o == 1) exp_s.push_back(mb1.pop_front());
                else exp_s.push_back(mb0.pop_front());
            end
            exp_b.push_back(b);
            rr_ptr = 1 - o;
        end
    endtask

    task automatic clear_logs();
        starts.delete(); rxs.delete(); falls.delete(); rises.delete(); elog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rq0.delete(); rq1.delete(); mb0.delete(); mb1.delete(); mbur0.delete(); mbur1.delete();
        cur0 = 0; cur1 = 0; pause = 2'b00; rr_ptr = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 clear_logs();
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        do begin
            @(posedge clk); #2;
            t++;
        end while (t < 3000 && (rq0.size() > 0 || rq1.size() > 0 || gnt_o != 2'b00 || ecnt > 0));
        repeat (4) @(posedge clk);
        #2 chk(tag, t < 3000, 1);
    endtask

    task automatic check_all();
        bur_t b;
        ev_t f, r, s, v;
        eng_t e;
        logic [7:0] x;
        int prev_rise, prev_rx;
        prev_rise = -1000;
        prev_rx = 0;
        while (exp_b.size() > 0) begin
            b = exp_b.pop_front();
            f = '{-1, -1, 8'h00};
            r = f;
            if (falls.size() > 0) f = falls.pop_front();
            if (rises.size() > 0) r = rises.pop_front();
            chk("fall_owner", f.o, b.o);
            chk("rise_owner", r.o, b.o);
            chk("idle_gap", (f.c - prev_rise) >= 1, 1);
            for (int k = 0; k < b.n; k++) begin
                s = '{-1, -1, 8'h00};
                v = s;
                e = '{8'h00, -1};
                x = 8'h00;
                if (starts.size() > 0) s = starts.pop_front();
                if (rxs.size() > 0) v = rxs.pop_front();
                if (elog.size() > 0) e = elog.pop_front();
                if (exp_s.size() > 0) x = exp_s.pop_front();
                chk("start_owner", s.o, b.o);
                chk("start_tx", s.b, x);
                if (k == 0) chk("setup_cycles", s.c - f.c, SU + 1 + b.extra);
                else chk("byte_gap", s.c - prev_rx, 2);
                chk("rx_owner", v.o, b.o);
                chk("rx_data", v.b, e.rx);
                chk("rx_latency", v.c - s.c, e.lat + 1);
                prev_rx = v.c;
            end
            chk("hold_cycles", r.c - prev_rx, HD + 1 + b.early);
            prev_rise = r.c;
        end
        chk("leftover_events", starts.size() + rxs.size() + falls.size() + rises.size() + elog.size(), 0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        do_reset();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_rxv", rx_valid_o, 0);
        chk("rst_start", eng_start_o, 0);
        chk("rst_eng_tx", eng_tx_o, 0);
        chk("rst_rx", rx_o, 0);
        chk("rst_ss", spi_ss_o, 3);

        fix_lat = 8; fix_rx = 'h3C;
        add(0, 8'hA5, 1'b1, 1'b0);
        plan(0);
        wait_idle("single_timeout");
        check_all();
        chk("single_rx_o", rx_o, 8'h3C);
        fix_lat = 0; fix_rx = -1;

        add(1, 8'h11, 1'b0, 1'b0);
        add(1, 8'h22, 1'b0, 1'b0);
        add(1, 8'h33, 1'b1, 1'b0);
        plan(0);
        wait_idle("burst3_timeout");
        check_all();

        do_reset();
        repeat (2) begin
            add(0, 8'($urandom), 1'b1, 1'b0);
            add(1, 8'($urandom), 1'b1, 1'b0);
        end
        plan(0);
        wait_idle("contend_timeout");
        check_all();

        busy_test = 1'b1;
        add(0, 8'hC7, 1'b1, 1'b0);
        plan(5);
        wait_idle("busy_timeout");
        check_all();

        add(0, 8'h5A, 1'b0, 1'b1);
        plan(0);
        wait_idle("early_timeout");
        check_all();

        stray = 1'b1;
        repeat (6) @(posedge clk);
        #2 chk("stray_rx", rxs.size(), 0);
        chk("stray_gnt", gnt_o, 0);

        fix_lat = 10;
        add(1, 8'h77, 1'b0, 1'b0);
        add(1, 8'h88, 1'b1, 1'b0);
        t = 0;
        while (starts.size() == 0 && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        chk("abort_start_seen", starts.size(), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_ss_async", spi_ss_o, 3);
        chk("abort_gnt_async", gnt_o, 0);
        do_reset();
        repeat (15) @(posedge clk);
        #2 chk("abort_no_rxv", rxs.size(), 0);
        chk("abort_no_start", starts.size(), 0);
        chk("abort_gnt_idle", gnt_o, 0);
        clear_logs();
        fix_lat = 0;

        add(1, 8'h9E, 1'b1, 1'b0);
        add(0, 8'h4B, 1'b1, 1'b0);
        plan(0);
        wait_idle("ptr_reset_timeout");
        check_all();

        for (int r = 0; r < 6; r++) begin
            int nb0, nb1, n;
            nb0 = int'($urandom_range(0, 2));
            nb1 = int'($urandom_range(0, 2));
            if (nb0 + nb1 == 0) nb0 = 1;
            for (int q = 0; q < nb0 + nb1; q++) begin
                n = int'($urandom_range(1, 3));
                for (int k = 0; k < n; k++) add(q < nb0 ? 0 : 1, 8'($urandom), k == n - 1, 1'b0);
            end
            plan(0);
            wait_idle("random_timeout");
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
